// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state encoding and op-field width.
package mdu_iter_pkg;

    localparam int MDU_OP_WIDTH = 3;

    typedef enum logic [2:0] {
        MduMul    = 3'd0,
        MduMulh   = 3'd1,
        MduMulhsu = 3'd2,
        MduMulhu  = 3'd3,
        MduDiv    = 3'd4,
        MduDivu   = 3'd5,
        MduRem    = 3'd6,
        MduRemu   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e o);
        return o inside {MduDiv, MduDivu, MduRem, MduRemu};
    endfunction

    function automatic logic op_is_rem(input mdu_op_e o);
        return o inside {MduRem, MduRemu};
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference if it did not borrow.
module mdu_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividend_bit,
    output logic [XLEN-1:0] rem_out,
    output logic            quo_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_in < divisor always holds, so a non-borrowing difference fits in XLEN bits
    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor};
        quo_bit = ~diff[XLEN];
        rem_out = quo_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: shift-add multiplier and restoring
// divider sharing one 2*XLEN accumulator, with fast-path divide corner cases.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int OP_WIDTH = MDU_OP_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] op,
    input  logic                is_word,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result
);

    localparam int CW = $clog2(XLEN) + 1;

    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic sx);
        logic [XLEN-1:0] r;
        r       = (sx && v[31]) ? '1 : '0;
        r[31:0] = v[31:0];
        return r;
    endfunction

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;
    mdu_op_e           op_q, op_d;
    logic              w_q, w_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;

    mdu_op_e         op_in;
    logic            is_div, is_rem, w_in, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0] a_eff, b_eff, mag1, mag2, min_eff, fast_res;

    // Request decode: effective-width operands, magnitudes and fast-path detection
    always_comb begin
        op_in    = mdu_op_e'(op[2:0]);
        is_div   = op_is_div(op_in);
        is_rem   = op_is_rem(op_in);
        w_in     = is_word && (XLEN > 32) && !(op_in inside {MduMulh, MduMulhsu, MduMulhu});
        sgn1     = op_in inside {MduMulh, MduMulhsu, MduDiv, MduRem};
        sgn2     = op_in inside {MduMulh, MduDiv, MduRem};
        a_eff    = w_in ? wext(src1, sgn1) : src1;
        b_eff    = w_in ? wext(src2, sgn2) : src2;
        neg1     = sgn1 & a_eff[XLEN-1];
        neg2     = sgn2 & b_eff[XLEN-1];
        mag1     = neg1 ? -a_eff : a_eff;
        mag2     = neg2 ? -b_eff : b_eff;
        min_eff  = '0;
        min_eff[XLEN-1] = 1'b1;
        if (w_in) begin
            min_eff = wext(XLEN'(32'h8000_0000), 1'b1);
        end
        div_zero = is_div && (b_eff == '0);
        div_ovf  = is_div && sgn2 && (a_eff == min_eff) && (b_eff == '1);
        fast_res = div_zero ? (is_rem ? a_eff : '1) : (is_rem ? '0 : min_eff);
    end

    logic [XLEN-1:0] step_rem;
    logic            step_quo;

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in       (acc_q[2*XLEN-1:XLEN]),
        .divisor      (opb_q),
        .dividend_bit (acc_q[XLEN-1]),
        .rem_out      (step_rem),
        .quo_bit      (step_quo)
    );

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_step, prod, prod_s;
    logic [XLEN-1:0]   quo, rem, final_res;

    // One iteration of the shared datapath plus sign fix-up of the final value
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        if (op_is_div(op_q)) begin
            acc_step = {step_rem, acc_q[XLEN-2:0], step_quo};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
        // a 32-step multiply leaves the product XLEN-32 bits too high
        prod   = w_q ? (acc_step >> (XLEN - 32)) : acc_step;
        prod_s = negq_q ? -prod : prod;
        quo    = acc_step[XLEN-1:0];
        rem    = acc_step[2*XLEN-1:XLEN];
        if (op_is_div(op_q)) begin
            if (op_is_rem(op_q)) begin
                final_res = negr_q ? -rem : rem;
            end else begin
                final_res = negq_q ? -quo : quo;
            end
        end else if (op_q == MduMul) begin
            final_res = prod_s[XLEN-1:0];
        end else begin
            final_res = prod_s[2*XLEN-1:XLEN];
        end
        if (w_q) begin
            final_res = wext(final_res, 1'b1);
        end
    end

    // Next-state, operand latching, iteration and result capture; flush wins
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        w_d      = w_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            MDU_IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op_in;
                    w_d    = w_in;
                    negq_d = neg1 ^ neg2;
                    negr_d = neg1;
                    acc_d  = '0;
                    if (is_div) begin
                        // dividend MSB must sit at the top of the low half
                        opb_d = mag2;
                        acc_d[XLEN-1:0] = w_in ? (mag1 << (XLEN - 32)) : mag1;
                    end else begin
                        opb_d = mag1;
                        acc_d[XLEN-1:0] = mag2;
                    end
                    if (div_zero || div_ovf) begin
                        state_d  = MDU_DONE;
                        result_d = w_in ? wext(fast_res, 1'b1) : fast_res;
                    end else begin
                        state_d = MDU_BUSY;
                        cnt_d   = w_in ? CW'(32) : CW'(XLEN);
                    end
                end
            end
            MDU_BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d  = MDU_DONE;
                    result_d = final_res;
                end
            end
            MDU_DONE: begin
                if (out_ready) begin
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
        if (flush) begin
            state_d = MDU_IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= MduMul;
            w_q      <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            w_q      <= w_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == MDU_IDLE);
    assign out_valid = (state_q == MDU_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (XLEN=64): directed vectors push expected
// result/latency on accept; a negedge monitor checks each presented result.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = 3'd0;
    logic            is_word = 1'b0;
    logic [XLEN-1:0] src1 = '0;
    logic [XLEN-1:0] src2 = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(XLEN), .OP_WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_word   (is_word),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare on first presentation of a result, pop on handshake
    always @(negedge clk) begin
        if (!rst && out_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                check("result", result, sb[0].res);
                check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            end
        end
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb.size() > 0) void'(sb.pop_front());
            seen = 1'b0;
        end
        if (!out_valid) seen = 1'b0;
    end

    task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] r, input int lat,
                         input logic push, output int at);
        exp_t e;
        at       = -1;
        op       = o;
        is_word  = w;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                at = cyc;
                if (push) begin
                    e.res = r;
                    e.acc = cyc;
                    e.lat = lat;
                    sb.push_back(e);
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic iss(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] r, input int lat);
        int at;
        issue(o, w, a, b, r, lat, 1'b1, at);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        int   at1, at2, dummy;
        logic saw;

        #12;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // multiply
        iss(MduMul,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        iss(MduMulhu,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        iss(MduMulhsu, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        iss(MduMulh,   1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 65);
        iss(MduMulhu,  1'b1, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        iss(MduMul,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        // divide fast paths
        iss(MduDivu, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        iss(MduRem,  1'b0, 64'd5, 64'd0, 64'd5, 1);
        iss(MduDiv,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        iss(MduRem,  1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        iss(MduDiv,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        iss(MduDivu, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        // iterative divide
        iss(MduDiv,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        iss(MduRem,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        iss(MduDivu, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
        iss(MduDiv,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        iss(MduRem,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65);
        drain();

        // back-to-back throughput with out_ready high
        issue(MduMul, 1'b0, 64'd3, 64'd5, 64'd15, 65, 1'b1, at1);
        issue(MduMul, 1'b0, 64'd6, 64'd5, 64'd30, 65, 1'b1, at2);
        check("throughput", 64'(at2 - at1), 64'd66);
        drain();

        // flush mid-divide
        issue(MduDiv, 1'b0, 64'd1000, 64'd3, 64'd0, 0, 1'b0, dummy);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        saw = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("flush_no_valid", 64'(saw), 64'd0);
        @(posedge clk);
        #1;
        iss(MduMul, 1'b0, 64'd3, 64'd4, 64'd12, 65);
        drain();

        // flush with in_valid in IDLE
        op       = MduMul;
        src1     = 64'd9;
        src2     = 64'd9;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("flush_accept_in_ready", 64'(in_ready), 64'd1);
        check("flush_accept_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // backpressure in DONE
        out_ready = 1'b0;
        iss(MduDivu, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        check("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_result", result, 64'd14);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // async reset mid-BUSY
        issue(MduMul, 1'b0, 64'd5, 64'd6, 64'd0, 0, 1'b0, dummy);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        iss(MduRemu, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit: the execute-stage companion to the single-cycle ALU, implementing the RISC-V M-extension ops (plus RV64 W-forms) for a parametrised XLEN. It is a shift-add multiplier and restoring divider sharing one datapath, with valid/ready handshakes on both sides and a pipeline flush input. Divide-by-zero and signed overflow complete on a fast path.

## Interface
- XLEN, 64: operand/result width; 32 or 64.
- OP_WIDTH, 3: width of op field.

- clk  in  1  clock, rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; equals (state == IDLE).
- op  in  OP_WIDTH  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- is_word  in  1  W-form (MULW/DIVW/DIVUW/REMW/REMUW). Ignored for ops 1-3 and when XLEN=32.
- src1, src2  in  XLEN  operands: rs1 and rs2.
- flush  in  1  abort any in-flight op and drop a pending result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.

## Operation
- States: IDLE, BUSY, DONE.
- Accept:
  - Accept occurs on in_valid & in_ready & ~flush.
  - Operands are latched with op, is_word and sign flags.
- W-form operand preparation:
  - Operands are truncated to 32 bits.
  - Sign-extension applies for signed ops; zero-extension applies for unsigned ops.
- Signed ops convert operands to magnitude on accept. The final sign is fixed in the DONE transition:
  - Product sign = s1 ^ s2.
  - Quotient sign = s1 ^ s2.
  - Remainder sign = s1.
- Multiply:
  - N iterations, one multiplier bit per cycle, into a 2N-bit accumulator.
  - MUL returns the low N bits; MULH* return the high N bits.
- Divide:
  - Restoring algorithm, N iterations, one quotient bit per cycle.
- Iteration count: N = 32 if is_word, else XLEN.
- Fast path (accept → DONE directly, no BUSY):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / −1, evaluated at effective width): quotient = MIN; remainder = 0.
- W-form result: the low 32 bits are sign-extended to XLEN, including DIVUW/REMUW.
- DONE:
  - out_valid = 1 and result stays stable until out_ready.
  - DONE → IDLE on out_ready.
  - No new accept occurs in the handshake cycle; in_ready rises the next cycle.
- Flush:
  - From any state, the next state is IDLE and out_valid = 0.
  - Flush has priority over a same-cycle accept and over a same-cycle out handshake; that result is considered consumed only if flush is low.
- Reset:
  - Async assert sets state to IDLE, out_valid to 0, result to 0, and the counter and accumulators to 0.
  - Reset mid-BUSY discards the operation.
  - in_valid is ignored while rst is high.

## Timing
- Accept at edge T:
  - Iterative op: BUSY for cycles T+1..T+N; out_valid first high in cycle T+N+1.
  - Fast path: out_valid high in cycle T+1.
- XLEN=64 latencies: full op 65 cycles accept-to-valid; W-form 33 cycles.
- Back-to-back throughput: one op per N+2 cycles with out_ready held high.
- Counter: log2(XLEN)+1 bits, loaded with N on accept, decremented each BUSY cycle; BUSY → DONE when the counter reaches 1.
- Combinational paths:
  - in_ready and out_valid are pure state decodes.
  - There is no combinational path from in_valid/out_ready to in_ready/out_valid.

## Structure
- Op encodings (MduMul..MduRemu), the state encoding and OP_WIDTH go into the shared defines header alongside the ALU op codes.
- Sub-module mdu_div_step is the single natural split:
  - Combinational one-bit restoring step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
  - Parametrised by XLEN.
- Top-level contents: FSM, counter, operand/sign registers, shared 2N-bit accumulator, final negate/sign-extend mux.

## Test plan
- MUL 7 × −3 (XLEN=64) → result 0xFFFFFFFFFFFFFFEB; out_valid exactly 65 cycles after accept.
- MULHU all-ones × all-ones → 0xFFFFFFFFFFFFFFFE; MULHSU −1 × 2 → 0xFFFFFFFFFFFFFFFF.
- DIVU 5 / 0 → 0xFFFFFFFFFFFFFFFF and REM 5 rem 0 → 5, both valid 1 cycle after accept; DIV 0x8000000000000000 / −1 → 0x8000000000000000 and REM → 0, also 1 cycle.
- DIVW −7 / 2 → 0xFFFFFFFFFFFFFFFD and REMW → 0xFFFFFFFFFFFFFFFF in 33 cycles; DIVUW 0x00000000_80000000 / 1 → 0xFFFFFFFF80000000.
- Flush 10 cycles into a DIV:
  - out_valid never rises and in_ready = 1 next cycle.
  - A following MUL 3 × 4 returns 12.
  - Flush asserted together with in_valid in IDLE leaves the unit IDLE.
- out_ready held low 5 cycles in DONE:
  - result and out_valid hold; in_ready = 0 throughout.
  - Handshake → in_ready = 1 the next cycle.
  - Async rst pulse mid-BUSY → out_valid = 0, result = 0 immediately.
